// File: rtl/matrix_mult_sequencer_if.sv
// Operand/result bus between the operand source, the matrix sequencer and the result consumer.
// The master side launches runs and captures results; the slave side is the sequencer.
interface matrix_mult_sequencer_if #(
  parameter int DATA_WIDTH = 3,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 8
);
  logic                        start;
  logic [N*N*DATA_WIDTH-1:0]   mat_a;
  logic [N*N*DATA_WIDTH-1:0]   mat_b;
  logic                        busy;
  logic                        done;
  logic [N*N*ACC_WIDTH-1:0]    result;

  modport master (output start, mat_a, mat_b, input busy, done, result);
  modport slave  (input start, mat_a, mat_b, output busy, done, result);
endinterface

// File: rtl/matrix_mult_sequencer.sv
// C = A*B for N x N signed matrices using one shared multiplier, one product per cycle
// in i, j, k order; result is valid during the single-cycle done pulse.
module multiplier #(
  parameter int W = 3
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);
  assign p = a * b;
endmodule

module matrix_mult_sequencer #(
  parameter int DATA_WIDTH = 3,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  matrix_mult_sequencer_if.slave     bus
);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int EL_W   = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;
  logic   accept;

  logic [N*N*DATA_WIDTH-1:0]     a_reg, b_reg;
  logic [IDX_W-1:0]              i_reg, j_reg, k_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;
  logic signed [ACC_WIDTH-1:0]   c_reg [N*N];

  logic signed [DATA_WIDTH-1:0]  a_elem [N*N];
  logic signed [DATA_WIDTH-1:0]  b_elem [N*N];
  logic [N*N*ACC_WIDTH-1:0]      result_flat;

  genvar gi;
  generate
    for (gi = 0; gi < N * N; gi++) begin : g_elem
      assign a_elem[gi] = a_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_elem[gi] = b_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign result_flat[gi*ACC_WIDTH +: ACC_WIDTH] = c_reg[gi];
    end
  endgenerate

  logic [EL_W-1:0] a_idx, b_idx, c_idx;
  assign a_idx = EL_W'(int'(i_reg) * N + int'(k_reg));
  assign b_idx = EL_W'(int'(k_reg) * N + int'(j_reg));
  assign c_idx = EL_W'(int'(i_reg) * N + int'(j_reg));

  logic signed [PROD_W-1:0]    mult_p;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;

  multiplier #(.W(DATA_WIDTH)) u_mult (
    .a (a_elem[a_idx]),
    .b (b_elem[b_idx]),
    .p (mult_p)
  );

  // Only the low 2*DATA_WIDTH bits carry the signed product.
  assign prod     = mult_p[PROD_W-1:0];
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum      = acc_reg + prod_ext;

  logic last_k, last_elem;
  assign last_k    = (k_reg == LAST);
  assign last_elem = last_k && (i_reg == LAST) && (j_reg == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = bus.start;
        if (bus.start) state_next = RUN;
      end
      RUN:  if (last_elem) state_next = DONE;
      DONE: begin
        accept     = bus.start;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_flat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      i_reg   <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
      acc_reg <= '0;
      for (int e = 0; e < N * N; e++) c_reg[e] <= '0;
    end else if (accept) begin
      a_reg   <= bus.mat_a;
      b_reg   <= bus.mat_b;
      i_reg   <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
      acc_reg <= '0;
      for (int e = 0; e < N * N; e++) c_reg[e] <= '0;
    end else if (state_reg == RUN) begin
      if (last_k) begin
        c_reg[c_idx] <= sum;
        acc_reg      <= '0;
        k_reg        <= '0;
        if (j_reg == LAST) begin
          j_reg <= '0;
          i_reg <= (i_reg == LAST) ? '0 : i_reg + IDX_W'(1);
        end else begin
          j_reg <= j_reg + IDX_W'(1);
        end
      end else begin
        acc_reg <= sum;
        k_reg   <= k_reg + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for the 2x2 sequencer: table-driven runs plus reset and back-to-back sequences.
module tb_matrix_mult_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mult_sequencer_if #(.DATA_WIDTH(3), .N(2), .ACC_WIDTH(8)) bus ();

  matrix_mult_sequencer #(.DATA_WIDTH(3), .N(2), .ACC_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic [31:0] c;
    int          sb_from;
    int          sb_to;
    bit          mutate;
  } vec_t;

  function automatic logic [11:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
  endfunction

  function automatic logic [31:0] pr(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    bus.mat_a = a;
    bus.mat_b = b;
    bus.start = 1'b1;
    @(posedge clk);
  endtask

  // Entered right after the accepting edge t0; follows the run to its done cycle.
  task automatic track(input string name, input logic [31:0] exp_c, input int sb_from,
                       input int sb_to, input bit mutate, input bit chain);
    int  edges = 0;
    int  bcyc  = 0;
    bit  seen  = 0;
    while (edges < 40) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) bcyc++;
      bus.start = (bcyc >= sb_from && bcyc <= sb_to);
      if (mutate && bcyc == 3) begin
        bus.mat_a = 12'($urandom);
        bus.mat_b = 12'($urandom);
      end
      @(posedge clk);
      edges++;
    end
    chk({name, " done_seen"}, 64'(seen), 64'd1);
    chk({name, " done_edge"}, 64'(edges), 64'd8);
    chk({name, " busy_cycles"}, 64'(bcyc), 64'd8);
    chk({name, " busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({name, " result"}, 64'(bus.result), 64'(exp_c));
    $display("run %s: edges=%0d busy_cycles=%0d result=%08h", name, edges, bcyc, bus.result);
    if (chain) begin
      bus.start = 1'b1;
      bus.mat_a = pk(1, 1, 1, 1);
      bus.mat_b = pk(1, 1, 1, 1);
      @(posedge clk);
    end else begin
      bus.start = 1'b0;
      @(negedge clk);
      chk({name, " done_pulse_len"}, 64'(bus.done), 64'd0);
      chk({name, " no_restart"}, 64'(bus.busy), 64'd0);
      chk({name, " result_stable"}, 64'(bus.result), 64'(exp_c));
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{"basic",    pk(1, 2, 3, -1),    pk(-2, 1, 0, 3),    pr(-2, 7, -6, 0),  99, 0, 1'b0};
    vecs[1] = '{"extreme",  pk(-4, -4, -4, -4), pk(-4, -4, -4, -4), pr(32, 32, 32, 32), 99, 0, 1'b0};
    vecs[2] = '{"identity", pk(1, 0, 0, 1),     pk(3, -4, -1, 2),   pr(3, -4, -1, 2),  99, 0, 1'b1};
    vecs[3] = '{"start_busy", pk(1, 2, 3, -1),  pk(-2, 1, 0, 3),    pr(-2, 7, -6, 0),  2, 5, 1'b0};

    bus.start = 1'b0;
    bus.mat_a = '0;
    bus.mat_b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 64'(bus.busy), 64'd0);

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].a, vecs[v].b);
      track(vecs[v].name, vecs[v].c, vecs[v].sb_from, vecs[v].sb_to, vecs[v].mutate, 1'b0);
    end

    // Asynchronous reset in the middle of RUN cycle 4, away from any clock edge.
    launch(pk(1, 2, 3, -1), pk(-2, 1, 0, 3));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset busy", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset busy", 64'(bus.busy), 64'd0);
    chk("async_reset done", 64'(bus.done), 64'd0);
    chk("async_reset result", 64'(bus.result), 64'd0);
    $display("async reset mid-run: busy=%0b done=%0b result=%08h", bus.busy, bus.done, bus.result);
    @(negedge clk);
    reset_n = 1'b1;
    launch(pk(1, 2, 3, -1), pk(-2, 1, 0, 3));
    track("after_reset", pr(-2, 7, -6, 0), 99, 0, 1'b0, 1'b0);

    // Back-to-back: start held through DONE with all-ones operands.
    launch(pk(1, 2, 3, -1), pk(-2, 1, 0, 3));
    track("b2b_first", pr(-2, 7, -6, 0), 99, 0, 1'b0, 1'b1);
    track("b2b_second", pr(2, 2, 2, 2), 99, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
